// File: rtl/ccu_pack_arb.sv
// Round-robin arbiter that streams one requester's packet bytes into a packer,
// then waits for the packer's busy pulse before releasing the grant.
module ccu_pack_arb #(
   parameter int N_REQ   = 4,
   parameter int TIMEOUT = 65535
) (
   input  logic                  clk,
   input  logic                  rstn,
   input  logic [N_REQ-1:0]      req,
   input  logic [16*N_REQ-1:0]   req_id,
   input  logic [13*N_REQ-1:0]   req_length,
   input  logic [8*N_REQ-1:0]    req_type,
   input  logic [8*N_REQ-1:0]    req_data,
   input  logic [N_REQ-1:0]      req_valid,
   output logic [N_REQ-1:0]      gnt,
   output logic [N_REQ-1:0]      req_ready,
   output logic [N_REQ-1:0]      done,
   output logic                  timeout_err,
   output logic                  pack_en,
   output logic [7:0]            pack_data,
   output logic [15:0]           pack_id,
   output logic [12:0]           pack_length,
   output logic [7:0]            pack_type,
   input  logic                  pack_busy
);

   localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

   typedef enum logic [1:0] {IDLE, STREAM, WAIT_BUSY, WAIT_DONE} state_t;

   state_t            state, state_nxt;
   logic [PW-1:0]     rr_ptr, win_idx, cand;
   logic              win_found;
   logic [N_REQ-1:0]  win_oh;
   logic [15:0]       win_id;
   logic [12:0]       win_len;
   logic [7:0]        win_type;
   logic [7:0]        sel_data;
   logic [12:0]       byte_cnt;
   logic [15:0]       wait_cnt, wait_cnt_inc;
   logic              stream_open, accept, last_byte, wait_expired;
   logic              grant_now, finish_ok, time_out;

   // Search starts one past the last winner, wrapping at N_REQ-1.
   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      cand      = rr_ptr;
      for (int k = 0; k < N_REQ; k++) begin
         cand = (cand == PW'(N_REQ - 1)) ? '0 : cand + 1'b1;
         if (!win_found && req[cand]) begin
            win_found = 1'b1;
            win_idx   = cand;
         end
      end
   end

   always_comb begin
      win_oh   = '0;
      win_id   = '0;
      win_len  = '0;
      win_type = '0;
      sel_data = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (win_idx == PW'(i)) begin
            win_oh[i] = 1'b1;
            win_id    = req_id[16*i +: 16];
            win_len   = req_length[13*i +: 13];
            win_type  = req_type[8*i +: 8];
         end
         if (gnt[i]) sel_data = req_data[8*i +: 8];
      end
   end

   // Handshake: a byte moves when req_valid[i] and req_ready[i] are high on the same edge.
   assign stream_open  = (state == STREAM) && (byte_cnt < pack_length);
   assign req_ready    = gnt & {N_REQ{stream_open}};
   assign accept       = |(req_valid & req_ready);
   assign last_byte    = accept && ((byte_cnt + 13'd1) == pack_length);
   assign wait_cnt_inc = wait_cnt + 16'd1;
   assign wait_expired = (wait_cnt_inc == 16'(TIMEOUT));

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      grant_now = 1'b0;
      finish_ok = 1'b0;
      time_out  = 1'b0;
      case (state)
         IDLE: begin
            if (!pack_busy && win_found) begin
               grant_now = 1'b1;
               state_nxt = STREAM;
            end
         end
         STREAM: begin
            if (pack_length == 13'd0) begin
               finish_ok = 1'b1;
               state_nxt = IDLE;
            end else if (last_byte) begin
               state_nxt = WAIT_BUSY;
            end
         end
         WAIT_BUSY: begin
            if (pack_busy) begin
               state_nxt = WAIT_DONE;
            end else if (wait_expired) begin
               time_out  = 1'b1;
               state_nxt = IDLE;
            end
         end
         WAIT_DONE: begin
            if (!pack_busy) begin
               finish_ok = 1'b1;
               state_nxt = IDLE;
            end else if (wait_expired) begin
               time_out  = 1'b1;
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         gnt         <= '0;
         done        <= '0;
         timeout_err <= 1'b0;
         pack_en     <= 1'b0;
         pack_data   <= '0;
         pack_id     <= '0;
         pack_length <= '0;
         pack_type   <= '0;
         byte_cnt    <= '0;
         wait_cnt    <= '0;
         rr_ptr      <= PW'(N_REQ - 1);
      end else begin
         done        <= finish_ok ? gnt : '0;
         timeout_err <= time_out;
         pack_en     <= accept;
         if (accept) begin
            pack_data <= sel_data;
            byte_cnt  <= byte_cnt + 13'd1;
         end
         if (grant_now) begin
            gnt         <= win_oh;
            rr_ptr      <= win_idx;
            pack_id     <= win_id;
            pack_length <= win_len;
            pack_type   <= win_type;
            byte_cnt    <= '0;
         end else if (finish_ok || time_out) begin
            gnt <= '0;
         end
         // Counter restarts on every state change so each wait state gets a full budget.
         if (state_nxt != state)
            wait_cnt <= '0;
         else if (state == WAIT_BUSY || state == WAIT_DONE)
            wait_cnt <= wait_cnt_inc;
      end
   end

endmodule

// File: tb/tb_ccu_pack_arb.sv
// Bench for ccu_pack_arb: directed vector table, reset/busy corner sequences,
// then random packets checked against a round-robin transaction model.
module tb_ccu_pack_arb;

   localparam int N = 4;

   logic          clk = 1'b0;
   logic          rstn;
   logic [N-1:0]  req, req_valid, gnt, req_ready, done;
   logic [16*N-1:0] req_id;
   logic [13*N-1:0] req_length;
   logic [8*N-1:0]  req_type, req_data;
   logic          timeout_err, pack_en, pack_busy;
   logic [7:0]    pack_data, pack_type;
   logic [15:0]   pack_id;
   logic [12:0]   pack_length;

   ccu_pack_arb #(.N_REQ(N), .TIMEOUT(16)) dut (
      .clk(clk), .rstn(rstn), .req(req), .req_id(req_id), .req_length(req_length),
      .req_type(req_type), .req_data(req_data), .req_valid(req_valid), .gnt(gnt),
      .req_ready(req_ready), .done(done), .timeout_err(timeout_err), .pack_en(pack_en),
      .pack_data(pack_data), .pack_id(pack_id), .pack_length(pack_length),
      .pack_type(pack_type), .pack_busy(pack_busy)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int done_cnt = 0;
   int to_cnt = 0;
   int model_ptr;
   logic [7:0] exp_q[$];
   logic [7:0] obs_q[$];
   logic [15:0] id_v[N];
   logic [12:0] len_v[N];
   logic [7:0]  typ_v[N];

   typedef struct {
      logic [3:0] mask;
      int         exp_idx;
      int         len;
      int         mode;   // 0 random valid, 1 let wait time out, 2 valid toggles
      logic       fixed;
   } vec_t;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   always @(posedge clk) begin
      #1;
      if (rstn) begin
         if (pack_en) obs_q.push_back(pack_data);
         if (done != 0) done_cnt++;
         if (timeout_err) to_cnt++;
         chk("gnt_onehot0", 64'($onehot0(gnt)), 64'd1);
         chk("ready_only_granted", 64'(req_ready & ~gnt), 64'd0);
      end
   end

   function automatic int model_pick(input logic [3:0] mask, input int ptr);
      for (int k = 1; k <= N; k++) begin
         int i;
         i = (ptr + k) % N;
         if (mask[i]) return i;
      end
      return -1;
   endfunction

   task automatic drive_fields();
      for (int i = 0; i < N; i++) begin
         req_id[16*i +: 16]     = id_v[i];
         req_length[13*i +: 13] = len_v[i];
         req_type[8*i +: 8]     = typ_v[i];
      end
   endtask

   task automatic run_pkt(input logic [3:0] mask, input int exp_idx, input int len, input int mode,
                          input logic fixed, input logic [15:0] fid, input logic [7:0] ftyp,
                          input logic [7:0] b0);
      logic [7:0] bytes[$];
      logic [3:0] oh;
      int sent, guard, start, d0, t0;
      bit phase;
      oh = 4'b0001 << exp_idx;
      for (int i = 0; i < N; i++) begin
         id_v[i]  = 16'($urandom);
         typ_v[i] = 8'($urandom);
         len_v[i] = 13'($urandom_range(0, 8191));
      end
      len_v[exp_idx] = 13'(len);
      if (fixed) begin
         id_v[exp_idx]  = fid;
         typ_v[exp_idx] = ftyp;
      end
      for (int k = 0; k < len; k++) bytes.push_back(fixed ? 8'(b0 + 8'(k * 17)) : 8'($urandom));
      drive_fields();
      exp_q.delete();
      obs_q.delete();
      pack_busy = 1'b0;
      req = mask;
      guard = 0;
      do begin
         @(negedge clk);
         guard++;
      end while (gnt == 0 && guard < 10);
      chk("grant", 64'(gnt), 64'(oh));
      if (gnt == 0) begin
         req = '0;
         return;
      end
      chk("pack_id", 64'(pack_id), 64'(id_v[exp_idx]));
      chk("pack_length", 64'(pack_length), 64'(len_v[exp_idx]));
      chk("pack_type", 64'(pack_type), 64'(typ_v[exp_idx]));
      req = '0;
      d0 = done_cnt;
      t0 = to_cnt;
      if (len == 0) begin
         @(negedge clk);
         chk("done_len0", 64'(done), 64'(oh));
         chk("gnt_clear_len0", 64'(gnt), 64'd0);
         chk("no_pack_en_len0", 64'(obs_q.size()), 64'd0);
         return;
      end
      sent = 0;
      guard = 0;
      phase = 1'b1;
      while (sent < len && guard < 200) begin
         chk("ready_stream", 64'(req_ready), 64'(oh));
         if (mode == 2) req_valid = phase ? oh : 4'b0000;
         else req_valid = 4'($urandom);
         for (int i = 0; i < N; i++) req_data[8*i +: 8] = 8'($urandom);
         req_data[8*exp_idx +: 8] = bytes[sent];
         if (req_valid[exp_idx] && req_ready[exp_idx]) begin
            exp_q.push_back(bytes[sent]);
            sent++;
         end
         phase = !phase;
         guard++;
         @(negedge clk);
      end
      chk("stream_sent", 64'(sent), 64'(len));
      req_valid = oh;
      req_data[8*exp_idx +: 8] = 8'h5A;
      chk("ready_after_last", 64'(req_ready), 64'd0);
      start = cyc;
      if (mode == 1) begin
         guard = 0;
         while (!timeout_err && guard < 40) begin
            @(negedge clk);
            req_valid = '0;
            guard++;
         end
         chk("timeout_delay", 64'(cyc - start), 64'd16);
         chk("no_done_on_timeout", 64'(done_cnt - d0), 64'd0);
         chk("gnt_clear_timeout", 64'(gnt), 64'd0);
      end else begin
         repeat ($urandom_range(0, 3)) begin
            @(negedge clk);
            req_valid = '0;
         end
         pack_busy = 1'b1;
         repeat ($urandom_range(1, 3)) @(negedge clk);
         req_valid = '0;
         pack_busy = 1'b0;
         @(negedge clk);
         chk("done", 64'(done), 64'(oh));
         chk("gnt_clear", 64'(gnt), 64'd0);
         @(negedge clk);
         chk("done_once", 64'(done_cnt - d0), 64'd1);
         chk("no_timeout", 64'(to_cnt - t0), 64'd0);
      end
      req_valid = '0;
      chk("byte_count", 64'(obs_q.size()), 64'(exp_q.size()));
      for (int k = 0; k < exp_q.size() && k < obs_q.size(); k++)
         chk("byte_data", 64'(obs_q[k]), 64'(exp_q[k]));
   endtask

   vec_t vecs[13];

   initial begin
      int acc, guard, widx;
      logic [3:0] m;
      vecs[0]  = '{4'b1111, 0, 1, 0, 1'b0};
      vecs[1]  = '{4'b1111, 1, 2, 0, 1'b0};
      vecs[2]  = '{4'b1111, 2, 0, 0, 1'b0};
      vecs[3]  = '{4'b1111, 3, 1, 0, 1'b0};
      vecs[4]  = '{4'b1111, 0, 1, 0, 1'b0};
      vecs[5]  = '{4'b0001, 0, 3, 0, 1'b1};
      vecs[6]  = '{4'b0100, 2, 0, 0, 1'b0};
      vecs[7]  = '{4'b1111, 3, 2, 1, 1'b0};
      vecs[8]  = '{4'b1111, 0, 1, 0, 1'b0};
      vecs[9]  = '{4'b0010, 1, 4, 2, 1'b0};
      vecs[10] = '{4'b1010, 3, 2, 0, 1'b0};
      vecs[11] = '{4'b1001, 0, 1, 0, 1'b0};
      vecs[12] = '{4'b1001, 3, 1, 0, 1'b0};

      rstn = 1'b0;
      req = '0; req_valid = '0; pack_busy = 1'b0;
      req_id = '0; req_length = '0; req_type = '0; req_data = '0;
      repeat (3) @(negedge clk);
      chk("rst_gnt", 64'(gnt), 64'd0);
      chk("rst_ready", 64'(req_ready), 64'd0);
      chk("rst_flags", 64'({done, timeout_err, pack_en}), 64'd0);
      chk("rst_pack", 64'({pack_data, pack_id, pack_length, pack_type}), 64'd0);
      rstn = 1'b1;
      model_ptr = N - 1;
      @(negedge clk);

      foreach (vecs[v]) begin
         run_pkt(vecs[v].mask, vecs[v].exp_idx, vecs[v].len, vecs[v].mode, vecs[v].fixed,
                 16'h1234, 8'h07, 8'hAA);
         model_ptr = vecs[v].exp_idx;
      end

      // Busy packer blocks arbitration even with requests pending.
      pack_busy = 1'b1;
      req = 4'b0110;
      repeat (4) @(negedge clk);
      chk("no_grant_while_busy", 64'(gnt), 64'd0);
      widx = model_pick(4'b0110, model_ptr);
      run_pkt(4'b0110, widx, 2, 0, 1'b0, 16'h0, 8'h0, 8'h0);
      model_ptr = widx;

      // Reset in the middle of a 5-byte packet aborts it silently.
      for (int i = 0; i < N; i++) len_v[i] = 13'd5;
      drive_fields();
      req = 4'b0001;
      guard = 0;
      do begin
         @(negedge clk);
         guard++;
      end while (gnt == 0 && guard < 10);
      req = '0;
      acc = 0;
      guard = 0;
      while (acc < 2 && guard < 20) begin
         req_valid = 4'b0001;
         req_data = 32'($urandom);
         if (req_ready[0]) acc++;
         guard++;
         @(negedge clk);
      end
      req_valid = '0;
      acc = done_cnt;
      rstn = 1'b0;
      #1;
      chk("abort_gnt", 64'(gnt), 64'd0);
      chk("abort_ready", 64'(req_ready), 64'd0);
      chk("abort_flags", 64'({done, timeout_err, pack_en}), 64'd0);
      chk("abort_pack", 64'({pack_data, pack_id, pack_length, pack_type}), 64'd0);
      repeat (2) @(negedge clk);
      rstn = 1'b1;
      chk("abort_no_done", 64'(done_cnt - acc), 64'd0);
      run_pkt(4'b0010, 1, 2, 0, 1'b0, 16'h0, 8'h0, 8'h0);
      model_ptr = 1;

      for (int r = 0; r < 30; r++) begin
         int len, mode;
         m = 4'($urandom_range(1, 15));
         len = $urandom_range(0, 6);
         mode = ($urandom_range(0, 7) == 0) ? 1 : (($urandom_range(0, 1) == 1) ? 2 : 0);
         widx = model_pick(m, model_ptr);
         run_pkt(m, widx, len, mode, 1'b0, 16'h0, 8'h0, 8'h0);
         model_ptr = widx;
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
